rhs_stim_sequencer: RTL and testbench
=====================================

RHS_STIM_SEQUENCER -- requirements
Module: rhs_stim_sequencer

Interface
REQ-001 Parameter TICK_CYCLES, default 2800: aclk cycles per 50 us timing unit at 56 MHz.
REQ-002 aclk  in  1  sole clock; all logic on rising edge.
REQ-003 aresetn  in  1  reset, asynchronous, active-low.
REQ-004 start  in  1  rising-edge-detected request to begin a stim train.
REQ-005 abort  in  1  level; forces train termination.
REQ-006 cfg_pulse_width  in  8  phase width in 50 us units; 0 treated as 1.
REQ-007 cfg_ipulse_delay  in  16  delay between pulses in 50 us units; 0 allowed.
REQ-008 cfg_num_pulse  in  8  pulse count minus one.
REQ-009 cfg_infinite  in  1  repeat pulses until abort.
REQ-010 cfg_ch_pos, cfg_ch_neg  in  5 each  positive and negative channel indices.
REQ-011 cfg_monopolar  in  1  1: negative channel unused.
REQ-012 cmd_valid, cmd_op[1:0], cmd_ch[4:0]  out  command to the SPI engine.
REQ-013 cmd_ready  in  1  SPI engine accepts when cmd_valid and cmd_ready are both high.
REQ-014 busy, done  out  1 each  status; done is sticky.
REQ-015 pulse_cnt  out  8  pulses completed in the current train.

Function
REQ-016 States: IDLE, CMD_P1, PH1, CMD_P2, PH2, CMD_OFF, DELAY, FINISH.
REQ-017 IDLE goes to CMD_P1 on a start rising edge, clears done and pulse_cnt, and captures all cfg_* into shadow registers.
REQ-018 CMD_P1 drives cmd_op=POS and cmd_ch=ch_pos, then holds to PH1 on handshake.
REQ-019 PH1 counts pulse_width ticks, then goes to CMD_P2.
REQ-020 CMD_P2 drives cmd_op=NEG with cmd_ch=ch_neg (bipolar) or ch_pos (monopolar), then goes to PH2.
REQ-021 PH2 counts pulse_width ticks, then goes to CMD_OFF.
REQ-022 CMD_OFF drives cmd_op=OFF and cmd_ch=ch_pos; on handshake it increments pulse_cnt.
REQ-023 After CMD_OFF: if more pulses remain, or shadow infinite is set, go to DELAY; if delay=0, go directly to CMD_P1. Otherwise go to FINISH.
REQ-024 DELAY counts ipulse_delay ticks, then goes to CMD_P1.
REQ-025 FINISH sets done=1 for the cycle, then returns to IDLE.
REQ-026 Phase timing is exact: the tick divider restarts on entry to PH1, PH2 and DELAY. A phase of N units lasts exactly N*TICK_CYCLES cycles.
REQ-027 cmd_valid, once asserted, holds high and keeps cmd_op and cmd_ch stable until the handshake; it is never withdrawn except by reset.
REQ-028 abort sampled high:
 - in PH1 or PH2: jump to CMD_OFF, then FINISH;
 - in DELAY: go to FINISH;
 - in any CMD_* state: complete the pending handshake first, then issue OFF if the stim was on, then FINISH.
REQ-029 A start edge while busy is ignored; cfg_* changes while busy have no effect until the next train.
REQ-030 pulse_cnt saturates at 255 in infinite mode.
REQ-031 busy=1 in every state except IDLE.
REQ-032 done clears only on a new start edge or reset.

Reset
REQ-033 Asynchronous assertion of aresetn forces state=IDLE and clears cmd_valid, busy, done, pulse_cnt, all counters and the shadow registers.
REQ-034 Reset mid-train drops cmd_valid immediately and issues no OFF command; the SPI engine is reset on the same aresetn.
REQ-035 Deassertion is synchronised to aclk upstream; the block requires nothing further.

Configuration
REQ-036 Macro RHS_STIM_INFINITE_EN.
 - Defined: cfg_infinite is honoured per REQ-023 and REQ-030.
 - Undefined: cfg_infinite is ignored, trains always end after cfg_num_pulse+1 pulses, and the port remains present.

Structure
REQ-037 Package rhs_stim_pkg holds:
 - the state enum;
 - the cmd_op enum: OFF=0, POS=1, NEG=2;
 - default TICK_CYCLES;
 - widths for pulse and delay fields.
REQ-038 Sub-module rhs_tick_gen is a restartable divider with inputs clear and enable and a one-cycle tick output every TICK_CYCLES cycles.

Verification
REQ-039 Short train. Stimulus: TICK_CYCLES=2800, pw=1, delay=16, num=1, bipolar, pos=17, neg=18, cmd_ready=1.
 - Required commands: POS/17, NEG/18, OFF/17, then after 16 ticks the same sequence again.
 - Then done=1 and pulse_cnt=2.
 - PH1 lasts exactly 2800 cycles; DELAY lasts exactly 44800 cycles.
REQ-040 Backpressure. Stimulus: cmd_ready held low for 10 cycles on each command.
 - cmd_valid, cmd_op and cmd_ch stay stable throughout.
 - Phase duration is measured from the handshake and remains exactly pw*TICK_CYCLES.
REQ-041 Abort in phase. Stimulus: abort mid-PH1 of pulse 0.
 - Required commands: OFF/17 next, then done=1 and pulse_cnt=1.
 - No further POS command is issued.
REQ-042 Monopolar with zero delay. Stimulus: monopolar, delay=0, num=0, pw=0.
 - Required commands: POS/17, NEG/17, OFF/17.
 - Each phase lasts 2800 cycles.
 - done=1.
REQ-043 Infinite mode, RHS_STIM_INFINITE_EN defined. Stimulus: cfg_infinite=1, num=0.
 - At least 3 pulses are generated, then abort ends the train.
 - With the macro undefined, exactly 1 pulse is generated.
REQ-044 Reset during PH2.
 - All outputs are 0 within the same cycle.
 - A subsequent start produces a clean train.

Source files
------------

// File: rtl/rhs_stim_pkg.sv
`default_nettype none
// ============================================================================
// Module  : rhs_stim_pkg
// Brief   : Shared types, field widths and defaults for the stim sequencer.
// Revision: 1.0 - initial release
// ============================================================================
package rhs_stim_pkg;

    localparam int DEF_TICK_CYCLES = 2800;
    localparam int PW_W            = 8;
    localparam int DLY_W           = 16;
    localparam int NUM_W           = 8;
    localparam int CH_W            = 5;
    localparam int OP_W            = 2;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CMD_P1  = 3'd1,
        ST_PH1     = 3'd2,
        ST_CMD_P2  = 3'd3,
        ST_PH2     = 3'd4,
        ST_CMD_OFF = 3'd5,
        ST_DELAY   = 3'd6,
        ST_FINISH  = 3'd7
    } state_e;

    typedef enum logic [OP_W-1:0] {
        OP_OFF = 2'd0,
        OP_POS = 2'd1,
        OP_NEG = 2'd2
    } cmd_op_e;

    // A zero phase width behaves as a single unit.
    function automatic logic [PW_W-1:0] eff_width(input logic [PW_W-1:0] w);
        return (w == '0) ? PW_W'(1) : w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rhs_tick_gen.sv
`default_nettype none
// ============================================================================
// Module  : rhs_tick_gen
// Brief   : Restartable divider; one-cycle tick every TICK_CYCLES enabled cycles.
// Revision: 1.0 - initial release
// ============================================================================
module rhs_tick_gen
    import rhs_stim_pkg::*;
#(
    parameter int TICK_CYCLES = DEF_TICK_CYCLES
) (
    input  logic aclk,
    input  logic aresetn,
    input  logic clear,
    input  logic enable,
    output logic tick
);

    localparam int CW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_CYCLES - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    // Tick is kept independent of clear so the caller may derive clear from it.
    assign tick = enable && (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable) begin
            cnt_d = tick ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/rhs_stim_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : rhs_stim_sequencer
// Brief   : Biphasic stim-train sequencer issuing POS/NEG/OFF commands to an
//           SPI engine. Define RHS_STIM_INFINITE_EN to honour cfg_infinite.
// Revision: 1.0 - initial release
// ============================================================================
module rhs_stim_sequencer
    import rhs_stim_pkg::*;
#(
    parameter int TICK_CYCLES = DEF_TICK_CYCLES
) (
    input  logic             aclk,
    input  logic             aresetn,
    input  logic             start,
    input  logic             abort,
    input  logic [PW_W-1:0]  cfg_pulse_width,
    input  logic [DLY_W-1:0] cfg_ipulse_delay,
    input  logic [NUM_W-1:0] cfg_num_pulse,
    input  logic             cfg_infinite,
    input  logic [CH_W-1:0]  cfg_ch_pos,
    input  logic [CH_W-1:0]  cfg_ch_neg,
    input  logic             cfg_monopolar,
    output logic             cmd_valid,
    output logic [OP_W-1:0]  cmd_op,
    output logic [CH_W-1:0]  cmd_ch,
    input  logic             cmd_ready,
    output logic             busy,
    output logic             done,
    output logic [NUM_W-1:0] pulse_cnt
);

`ifdef RHS_STIM_INFINITE_EN
    localparam logic INF_EN = 1'b1;
`else
    localparam logic INF_EN = 1'b0;
`endif

    state_e             state_q, state_d;
    logic               start_q, start_d;
    logic [PW_W-1:0]    pw_q, pw_d;
    logic [DLY_W-1:0]   dly_q, dly_d;
    logic [NUM_W-1:0]   num_q, num_d;
    logic               inf_q, inf_d;
    logic [CH_W-1:0]    pos_q, pos_d;
    logic [CH_W-1:0]    neg_q, neg_d;
    logic               mono_q, mono_d;
    logic [NUM_W-1:0]   pcnt_q, pcnt_d;
    logic               done_q, done_d;
    logic               abort_q, abort_d;
    logic [DLY_W-1:0]   unit_q, unit_d;

    logic               start_edge, hs, abort_any, more, timed, tick, unit_done;
    logic [DLY_W-1:0]   target;

    assign start_edge = start && !start_q;
    assign hs         = cmd_valid && cmd_ready;
    assign abort_any  = abort || abort_q;
    assign more       = (pcnt_q < num_q) || inf_q;
    assign timed      = (state_q == ST_PH1) || (state_q == ST_PH2) || (state_q == ST_DELAY);
    assign target     = (state_q == ST_DELAY) ? dly_q : {{(DLY_W-PW_W){1'b0}}, eff_width(pw_q)};
    assign unit_done  = tick && (unit_q == target - 1'b1);

    // Divider restarts on every state change so each timed state starts aligned.
    rhs_tick_gen #(
        .TICK_CYCLES (TICK_CYCLES)
    ) u_tick (
        .aclk    (aclk),
        .aresetn (aresetn),
        .clear   (state_d != state_q),
        .enable  (timed),
        .tick    (tick)
    );

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:    if (start_edge) state_d = ST_CMD_P1;
            ST_CMD_P1:  if (hs) state_d = abort_any ? ST_CMD_OFF : ST_PH1;
            ST_PH1: begin
                if (abort)          state_d = ST_CMD_OFF;
                else if (unit_done) state_d = ST_CMD_P2;
            end
            ST_CMD_P2:  if (hs) state_d = abort_any ? ST_CMD_OFF : ST_PH2;
            ST_PH2:     if (abort || unit_done) state_d = ST_CMD_OFF;
            ST_CMD_OFF: begin
                if (hs) begin
                    if (abort_any || !more) state_d = ST_FINISH;
                    else if (dly_q == '0)   state_d = ST_CMD_P1;
                    else                    state_d = ST_DELAY;
                end
            end
            ST_DELAY: begin
                if (abort)          state_d = ST_FINISH;
                else if (unit_done) state_d = ST_CMD_P1;
            end
            ST_FINISH:  state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        cmd_valid = 1'b0;
        cmd_op    = OP_OFF;
        cmd_ch    = '0;
        case (state_q)
            ST_CMD_P1: begin
                cmd_valid = 1'b1;
                cmd_op    = OP_POS;
                cmd_ch    = pos_q;
            end
            ST_CMD_P2: begin
                cmd_valid = 1'b1;
                cmd_op    = OP_NEG;
                cmd_ch    = mono_q ? pos_q : neg_q;
            end
            ST_CMD_OFF: begin
                cmd_valid = 1'b1;
                cmd_op    = OP_OFF;
                cmd_ch    = pos_q;
            end
            default: ;
        endcase
        busy      = (state_q != ST_IDLE);
        done      = done_q;
        pulse_cnt = pcnt_q;
    end

    always_comb begin
        start_d = start;
        pw_d    = pw_q;
        dly_d   = dly_q;
        num_d   = num_q;
        inf_d   = inf_q;
        pos_d   = pos_q;
        neg_d   = neg_q;
        mono_d  = mono_q;
        pcnt_d  = pcnt_q;
        done_d  = done_q;
        abort_d = abort_q;
        unit_d  = unit_q;

        if (state_d != state_q) unit_d = '0;
        else if (tick)          unit_d = unit_q + 1'b1;

        if (state_q == ST_IDLE) begin
            if (start_edge) begin
                pw_d    = cfg_pulse_width;
                dly_d   = cfg_ipulse_delay;
                num_d   = cfg_num_pulse;
                inf_d   = cfg_infinite && INF_EN;
                pos_d   = cfg_ch_pos;
                neg_d   = cfg_ch_neg;
                mono_d  = cfg_monopolar;
                pcnt_d  = '0;
                done_d  = 1'b0;
                abort_d = 1'b0;
            end
        end else if (state_q != ST_FINISH && abort) begin
            abort_d = 1'b1;
        end

        if (state_q == ST_CMD_OFF && hs && pcnt_q != '1) pcnt_d = pcnt_q + 1'b1;
        if (state_d == ST_FINISH) done_d = 1'b1;
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            start_q <= 1'b0;
            pw_q    <= '0;
            dly_q   <= '0;
            num_q   <= '0;
            inf_q   <= 1'b0;
            pos_q   <= '0;
            neg_q   <= '0;
            mono_q  <= 1'b0;
            pcnt_q  <= '0;
            done_q  <= 1'b0;
            abort_q <= 1'b0;
            unit_q  <= '0;
        end else begin
            start_q <= start_d;
            pw_q    <= pw_d;
            dly_q   <= dly_d;
            num_q   <= num_d;
            inf_q   <= inf_d;
            pos_q   <= pos_d;
            neg_q   <= neg_d;
            mono_q  <= mono_d;
            pcnt_q  <= pcnt_d;
            done_q  <= done_d;
            abort_q <= abort_d;
            unit_q  <= unit_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_rhs_stim_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : tb_rhs_stim_sequencer
// Brief   : Self-checking bench: command trace and timing vs. a train model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_rhs_stim_sequencer;
    import rhs_stim_pkg::*;

    localparam int T = 16;

    logic        aclk, aresetn, start, abort;
    logic [7:0]  cfg_pulse_width;
    logic [15:0] cfg_ipulse_delay;
    logic [7:0]  cfg_num_pulse;
    logic        cfg_infinite, cfg_monopolar;
    logic [4:0]  cfg_ch_pos, cfg_ch_neg;
    logic        cmd_valid, cmd_ready, busy, done;
    logic [1:0]  cmd_op;
    logic [4:0]  cmd_ch;
    logic [7:0]  pulse_cnt;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int ready_mode = 0;
    int q_op[$], q_ch[$], q_gap[$];
    int e_op[$], e_ch[$], e_gap[$];

    rhs_stim_sequencer #(.TICK_CYCLES(T)) dut (
        .aclk(aclk), .aresetn(aresetn), .start(start), .abort(abort),
        .cfg_pulse_width(cfg_pulse_width), .cfg_ipulse_delay(cfg_ipulse_delay),
        .cfg_num_pulse(cfg_num_pulse), .cfg_infinite(cfg_infinite),
        .cfg_ch_pos(cfg_ch_pos), .cfg_ch_neg(cfg_ch_neg), .cfg_monopolar(cfg_monopolar),
        .cmd_valid(cmd_valid), .cmd_op(cmd_op), .cmd_ch(cmd_ch), .cmd_ready(cmd_ready),
        .busy(busy), .done(done), .pulse_cnt(pulse_cnt)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Command monitor: records each command, its gap since the previous
    // handshake, drives cmd_ready and checks that pending commands hold.
    initial begin : monitor
        int  last_hs = 0;
        int  wait_n = 0;
        bit  prev_valid = 0, prev_hs = 0, hs;
        logic [1:0] prev_op = '0;
        logic [4:0] prev_ch = '0;
        cmd_ready = 1'b1;
        forever begin
            @(negedge aclk);
            cyc++;
            if (!aresetn) begin
                prev_valid = 0;
                prev_hs = 0;
                continue;
            end
            if (prev_valid && !prev_hs) begin
                check("hold_valid", cmd_valid, 1);
                check("hold_op", cmd_op, prev_op);
                check("hold_ch", cmd_ch, prev_ch);
            end
            if (cmd_valid && (!prev_valid || prev_hs)) begin
                q_op.push_back(int'(cmd_op));
                q_ch.push_back(int'(cmd_ch));
                q_gap.push_back(cyc - last_hs - 1);
                wait_n = 0;
            end else if (cmd_valid) begin
                wait_n++;
            end
            case (ready_mode)
                1:       cmd_ready = 1'($urandom_range(0, 1));
                2:       cmd_ready = (wait_n >= 10);
                default: cmd_ready = 1'b1;
            endcase
            hs = cmd_valid && cmd_ready;
            if (hs) last_hs = cyc;
            prev_valid = cmd_valid;
            prev_hs = hs;
            prev_op = cmd_op;
            prev_ch = cmd_ch;
        end
    end

    task automatic tick_wait(input int n);
        repeat (n) @(negedge aclk);
    endtask

    task automatic set_cfg(input int pw, input int dly, input int num, input bit inf,
                           input int pos, input int neg, input bit mono);
        cfg_pulse_width  = 8'(pw);
        cfg_ipulse_delay = 16'(dly);
        cfg_num_pulse    = 8'(num);
        cfg_infinite     = inf;
        cfg_ch_pos       = 5'(pos);
        cfg_ch_neg       = 5'(neg);
        cfg_monopolar    = mono;
    endtask

    // Train model: per pulse POS, NEG, OFF; gap before each is the preceding
    // timed interval in cycles (-1 = not checked).
    task automatic build_expected(input int pw, input int dly, input int num,
                                  input bit mono, input int pos, input int neg);
        int pwe;
        pwe = (pw == 0) ? 1 : pw;
        e_op.delete(); e_ch.delete(); e_gap.delete();
        for (int p = 0; p <= num; p++) begin
            e_op.push_back(int'(OP_POS)); e_ch.push_back(pos);
            e_gap.push_back(p == 0 ? -1 : dly * T);
            e_op.push_back(int'(OP_NEG)); e_ch.push_back(mono ? pos : neg);
            e_gap.push_back(pwe * T);
            e_op.push_back(int'(OP_OFF)); e_ch.push_back(pos);
            e_gap.push_back(pwe * T);
        end
    endtask

    task automatic compare_trace(input string tag);
        check({tag, "_ncmd"}, q_op.size(), e_op.size());
        for (int i = 0; i < q_op.size() && i < e_op.size(); i++) begin
            check($sformatf("%s_op%0d", tag, i), q_op[i], e_op[i]);
            check($sformatf("%s_ch%0d", tag, i), q_ch[i], e_ch[i]);
            if (e_gap[i] >= 0) check($sformatf("%s_gap%0d", tag, i), q_gap[i], e_gap[i]);
        end
    endtask

    task automatic pulse_start(input string tag);
        q_op.delete(); q_ch.delete(); q_gap.delete();
        @(negedge aclk); start = 1'b1;
        @(negedge aclk); start = 1'b0;
        check({tag, "_busy_on"}, busy, 1);
        check({tag, "_done_clr"}, done, 0);
        check({tag, "_cnt_clr"}, pulse_cnt, 0);
    endtask

    task automatic wait_done(input string tag, input int budget);
        int k = 0;
        while (!done && k < budget) begin @(negedge aclk); k++; end
        check({tag, "_done"}, done, 1);
    endtask

    task automatic wait_size(input string tag, input int n, input int budget);
        int k = 0;
        while (q_op.size() < n && k < budget) begin @(negedge aclk); k++; end
        check({tag, "_reached"}, q_op.size() >= n, 1);
    endtask

    task automatic run_train(input string tag, input int pw, input int dly, input int num,
                             input bit mono, input int pos, input int neg, input bit disturb);
        set_cfg(pw, dly, num, 1'b0, pos, neg, mono);
        build_expected(pw, dly, num, mono, pos, neg);
        pulse_start(tag);
        if (disturb) begin
            tick_wait(3);
            set_cfg($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), 1'b1,
                    $urandom_range(0, 31), $urandom_range(0, 31), 1'($urandom_range(0, 1)));
            @(negedge aclk); start = 1'b1;
            @(negedge aclk); start = 1'b0;
        end
        wait_done(tag, 6000);
        tick_wait(4);
        check({tag, "_busy_off"}, busy, 0);
        check({tag, "_done_sticky"}, done, 1);
        check({tag, "_pcnt"}, pulse_cnt, num + 1);
        compare_trace(tag);
    endtask

    initial begin : stim
        aresetn = 1'b0; start = 1'b0; abort = 1'b0;
        set_cfg(0, 0, 0, 1'b0, 0, 0, 1'b0);
        tick_wait(3);
        check("rst_valid", cmd_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_pcnt", pulse_cnt, 0);
        @(negedge aclk); aresetn = 1'b1;
        tick_wait(2);
        check("idle_busy", busy, 0);

        ready_mode = 0;
        run_train("short", 1, 16, 1, 1'b0, 17, 18, 1'b0);

        ready_mode = 2;
        run_train("bp", 2, 1, 1, 1'b0, 17, 18, 1'b0);

        ready_mode = 0;
        run_train("mono0", 0, 0, 0, 1'b1, 17, 18, 1'b0);

        ready_mode = 1;
        for (int i = 0; i < 6; i++) begin
            run_train($sformatf("rnd%0d", i), $urandom_range(0, 3), $urandom_range(0, 3),
                      $urandom_range(0, 3), 1'($urandom_range(0, 1)),
                      $urandom_range(0, 31), $urandom_range(0, 31), 1'(i % 2));
        end

        ready_mode = 0;
        set_cfg(3, 2, 3, 1'b0, 17, 18, 1'b0);
        pulse_start("abph");
        tick_wait(T);
        abort = 1'b1;
        wait_done("abph", 2000);
        abort = 1'b0;
        tick_wait(4);
        build_expected(3, 2, 0, 1'b0, 17, 18);
        e_op[1] = int'(OP_OFF); e_ch[1] = 17; e_gap[1] = -1;
        e_op.pop_back(); e_ch.pop_back(); e_gap.pop_back();
        compare_trace("abph");
        check("abph_pcnt", pulse_cnt, 1);

        set_cfg(1, 8, 3, 1'b0, 9, 4, 1'b0);
        pulse_start("abdl");
        wait_size("abdl", 3, 500);
        tick_wait(T + 4);
        abort = 1'b1;
        wait_done("abdl", 500);
        abort = 1'b0;
        tick_wait(4);
        build_expected(1, 8, 0, 1'b0, 9, 4);
        compare_trace("abdl");
        check("abdl_pcnt", pulse_cnt, 1);

        set_cfg(1, 1, 0, 1'b1, 5, 6, 1'b0);
        pulse_start("inf");
`ifdef RHS_STIM_INFINITE_EN
        wait_size("inf", 9, 2000);
        abort = 1'b1;
        wait_done("inf", 2000);
        abort = 1'b0;
        tick_wait(4);
        build_expected(1, 1, 2, 1'b0, 5, 6);
        compare_trace("inf");
        check("inf_pcnt", pulse_cnt, 3);
`else
        wait_done("inf", 2000);
        tick_wait(4);
        build_expected(1, 1, 0, 1'b0, 5, 6);
        compare_trace("inf");
        check("inf_pcnt", pulse_cnt, 1);
`endif

        set_cfg(2, 1, 1, 1'b0, 17, 18, 1'b0);
        pulse_start("rstph2");
        wait_size("rstph2", 2, 500);
        tick_wait(T);
        #2 aresetn = 1'b0;
        #1;
        check("rstph2_valid", cmd_valid, 0);
        check("rstph2_op", cmd_op, 0);
        check("rstph2_ch", cmd_ch, 0);
        check("rstph2_busy", busy, 0);
        check("rstph2_done", done, 0);
        check("rstph2_pcnt", pulse_cnt, 0);
        @(negedge aclk); aresetn = 1'b1;
        tick_wait(2);
        run_train("post_rst", 1, 2, 1, 1'b0, 3, 30, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
